// File: rtl/ifq_pkg.sv
// rtl/ifq_pkg.sv - shared fetch-queue types and constants
// Purpose: line geometry, line type and fetch FSM state encoding shared by
//          the line fetcher, the fetch queue and decode.
// Ports:   none (package).
package ifq_pkg;

  localparam int LINE_BYTES     = 16;
  localparam int WORDS_PER_LINE = 4;

  typedef logic [127:0] line_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    PUSH = 3'd3,
    DROP = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/ifq_line_fetcher.sv
// rtl/ifq_line_fetcher.sv - sequential instruction line fetcher feeding the fetch queue
// Purpose: walks 16-byte instruction lines from instruction memory and pushes
//          them into the fetch queue; on a redirect it squashes in-flight work,
//          fetches the target line and delivers it with a queue flush.
// Ports:
//   i_clk, i_rst_n                    clock, asynchronous active-low reset
//   i_redirect, i_redirect_addr       one-cycle redirect pulse and target byte address
//   o_req_valid, o_req_addr,
//   i_req_ready                       line read request handshake to memory
//   i_rsp_valid, i_rsp_data           in-order line response from memory
//   i_q_full                          fetch queue back-pressure
//   o_q_wr_en, o_q_flush,
//   o_q_word_sel, o_q_data            queue push / flush-and-load interface
//   o_redirect_pending                redirect accepted, target line not yet delivered
module ifq_line_fetcher
  import ifq_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    LINE_WIDTH = 128,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0040_0000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_redirect,
  input  logic [ADDR_WIDTH-1:0] i_redirect_addr,
  output logic                  o_req_valid,
  output logic [ADDR_WIDTH-1:0] o_req_addr,
  input  logic                  i_req_ready,
  input  logic                  i_rsp_valid,
  input  logic [LINE_WIDTH-1:0] i_rsp_data,
  input  logic                  i_q_full,
  output logic                  o_q_wr_en,
  output logic                  o_q_flush,
  output logic [1:0]            o_q_word_sel,
  output logic [LINE_WIDTH-1:0] o_q_data,
  output logic                  o_redirect_pending
);

  localparam int                    OFF_W     = $clog2(LINE_BYTES);
  localparam int                    WSEL_LSB  = $clog2(LINE_BYTES / WORDS_PER_LINE);
  localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(LINE_BYTES);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] line_addr_q, line_addr_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic [1:0]            tgt_sel_q, tgt_sel_d;
  logic                  flush_mark_q, flush_mark_d;
  logic                  pending_q, pending_d;
  logic                  req_valid_q, req_valid_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic                  wr_en_q, wr_en_d;
  logic                  flush_q, flush_d;
  logic [1:0]            word_sel_q, word_sel_d;

  logic                  xfer;
  logic [ADDR_WIDTH-1:0] tgt_line;

  // Byte offset within a 32-bit word never matters for instruction selection.
  logic unused_addr_bits;
  assign unused_addr_bits = ^i_redirect_addr[WSEL_LSB-1:0];

  assign xfer     = req_valid_q && i_req_ready;
  assign tgt_line = {i_redirect_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

  always_comb begin
    state_d      = state_q;
    line_addr_d  = line_addr_q;
    line_d       = line_q;
    tgt_sel_d    = tgt_sel_q;
    flush_mark_d = flush_mark_q;
    pending_d    = pending_q;
    wr_en_d      = 1'b0;
    flush_d      = 1'b0;

    // Pending stays up through the flush cycle itself and drops right after.
    if (flush_q) begin
      pending_d = 1'b0;
    end

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (xfer) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (i_rsp_valid) begin
          line_d  = i_rsp_data;
          state_d = PUSH;
        end
      end
      PUSH: begin
        if (flush_mark_q) begin
          // Target line: flush delivery ignores back-pressure since the
          // queue is emptied by the flush anyway.
          flush_d      = 1'b1;
          flush_mark_d = 1'b0;
          line_addr_d  = line_addr_q + LINE_STEP;
          state_d      = REQ;
        end else if (!i_q_full) begin
          wr_en_d     = 1'b1;
          line_addr_d = line_addr_q + LINE_STEP;
          state_d     = REQ;
        end
      end
      DROP: begin
        if (i_rsp_valid) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    // A redirect overrides whatever the state above decided; the only thing
    // that survives is the knowledge of whether a stale response is owed.
    if (i_redirect) begin
      tgt_sel_d    = i_redirect_addr[OFF_W-1:WSEL_LSB];
      line_addr_d  = tgt_line;
      line_d       = line_q;
      pending_d    = 1'b1;
      flush_mark_d = 1'b1;
      wr_en_d      = 1'b0;
      flush_d      = 1'b0;
      case (state_q)
        REQ:     state_d = xfer ? DROP : REQ;
        WAIT:    state_d = i_rsp_valid ? REQ : DROP;
        DROP:    state_d = i_rsp_valid ? REQ : DROP;
        default: state_d = REQ;
      endcase
    end

    req_valid_d = (state_d == REQ);
    req_addr_d  = line_addr_d;
    word_sel_d  = flush_d ? tgt_sel_q : 2'b00;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      line_addr_q  <= RESET_PC;
      line_q       <= '0;
      tgt_sel_q    <= 2'b00;
      flush_mark_q <= 1'b0;
      pending_q    <= 1'b0;
      req_valid_q  <= 1'b0;
      req_addr_q   <= RESET_PC;
      wr_en_q      <= 1'b0;
      flush_q      <= 1'b0;
      word_sel_q   <= 2'b00;
    end else begin
      state_q      <= state_d;
      line_addr_q  <= line_addr_d;
      line_q       <= line_d;
      tgt_sel_q    <= tgt_sel_d;
      flush_mark_q <= flush_mark_d;
      pending_q    <= pending_d;
      req_valid_q  <= req_valid_d;
      req_addr_q   <= req_addr_d;
      wr_en_q      <= wr_en_d;
      flush_q      <= flush_d;
      word_sel_q   <= word_sel_d;
    end
  end

  assign o_req_valid        = req_valid_q;
  assign o_req_addr         = req_addr_q;
  assign o_q_wr_en          = wr_en_q;
  assign o_q_flush          = flush_q;
  assign o_q_word_sel       = word_sel_q;
  assign o_q_data           = line_q;
  assign o_redirect_pending = pending_q;

endmodule
